// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: default depth, bus widths
// and loader state encoding.
package inst_rom_loader_pkg;

  localparam int unsigned ROM_DEPTH_LOG2_DEF = 10;
  localparam int unsigned INST_W             = 32;
  localparam int unsigned BUS_ADDR_W         = 32;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are never cleared, so unwritten words keep whatever they last held.
module inst_rom_mem
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Loads a big-endian byte stream into the instruction store, holds the CPU in
// reset until a complete image is present, then serves zero-latency fetches.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ROM_DEPTH_LOG2 = ROM_DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [BUS_ADDR_W-1:0] rom_addr,
  output logic [INST_W-1:0]     rom_inst,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  load_restart,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_error
);

  state_t                  state;
  logic [ROM_DEPTH_LOG2:0] word_ptr;
  logic [1:0]              byte_cnt;
  logic [23:0]             asm_word;
  logic                    store_full;
  logic                    mem_we;
  logic                    rd_hit;
  logic [INST_W-1:0]       rd_data;

  assign load_ready = (state == ST_LOAD);
  assign load_done  = (state == ST_RUN);
  assign load_error = (state == ST_ERROR);

  // word_ptr never exceeds the depth, so its MSB alone flags a full store
  assign store_full = word_ptr[ROM_DEPTH_LOG2];
  assign mem_we     = load_ready && load_valid && !store_full && (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOAD;
      word_ptr <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      cpu_rst  <= 1'b1;
    end else begin
      // Releases one cycle after entering RUN; reasserts on the restart edge
      cpu_rst <= !((state == ST_RUN) && !load_restart);
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            if (store_full) begin
              state <= ST_ERROR;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                word_ptr <= word_ptr + 1'b1;
                if (load_last) state <= ST_RUN;
              end else begin
                asm_word <= {asm_word[15:0], load_data};
                if (load_last) state <= ST_ERROR;
              end
            end
          end
        end
        ST_RUN, ST_ERROR: begin
          if (load_restart) begin
            state    <= ST_LOAD;
            word_ptr <= '0;
            byte_cnt <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  inst_rom_mem #(
    .ADDR_W (ROM_DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_ptr[ROM_DEPTH_LOG2-1:0]),
    .wdata ({asm_word, load_data}),
    .raddr (rom_addr[ROM_DEPTH_LOG2+1:2]),
    .rdata (rd_data)
  );

  assign rd_hit = rom_en && (state == ST_RUN) && (rom_addr[1:0] == 2'b00) &&
                  ((rom_addr >> (ROM_DEPTH_LOG2 + 2)) == '0);
  assign rom_inst = rd_hit ? rd_data : '0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed scenarios plus randomized
// images checked against a word-level reference store.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic        rom_en, rom_en_b;
  logic [31:0] rom_addr, rom_addr_b;
  logic [31:0] rom_inst, rom_inst_b;
  logic        load_valid, load_valid_b;
  logic [7:0]  load_data, load_data_b;
  logic        load_last, load_last_b;
  logic        load_ready, load_ready_b;
  logic        load_restart, load_restart_b;
  logic        cpu_rst, cpu_rst_b;
  logic        load_done, load_done_b;
  logic        load_error, load_error_b;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  inst_rom_loader dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_restart(load_restart), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_error(load_error)
  );

  inst_rom_loader #(.ROM_DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(rst_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_inst(rom_inst_b),
    .load_valid(load_valid_b), .load_data(load_data_b), .load_last(load_last_b),
    .load_ready(load_ready_b), .load_restart(load_restart_b), .cpu_rst(cpu_rst_b),
    .load_done(load_done_b), .load_error(load_error_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic last, input logic rs);
    if (sel == 0) begin
      load_valid = 1'b1; load_data = d; load_last = last; load_restart = rs;
    end else begin
      load_valid_b = 1'b1; load_data_b = d; load_last_b = last; load_restart_b = rs;
    end
    @(posedge clk); #1;
    load_valid = 1'b0; load_last = 1'b0; load_restart = 1'b0;
    load_valid_b = 1'b0; load_last_b = 1'b0; load_restart_b = 1'b0;
  endtask

  task automatic idle(input int sel, input logic rs);
    if (sel == 0) load_restart = rs; else load_restart_b = rs;
    @(posedge clk); #1;
    load_restart = 1'b0; load_restart_b = 1'b0;
  endtask

  task automatic load_bytes(input int sel, input logic [7:0] img [$], input bit with_last,
                            input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(sel, 1'($urandom_range(0, 1)));
      send(sel, img[i], with_last && (i == img.size() - 1),
           gaps ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic rd_chk(input string tag, input int sel, input logic en,
                        input logic [31:0] addr, input logic [31:0] exp);
    if (sel == 0) begin rom_en = en; rom_addr = addr; end
    else begin rom_en_b = en; rom_addr_b = addr; end
    #1;
    chk(tag, (sel == 0) ? rom_inst : rom_inst_b, exp);
  endtask

  // Expected fetch result for the default-depth DUT while running.
  function automatic logic [31:0] model_read(input logic en, input logic [31:0] addr);
    if (!en) return 32'h0;
    if (addr % 4 != 0) return 32'h0;
    if (addr >= 32'd4096) return 32'h0;
    if (!ref_mem.exists(int'(addr / 4))) return 32'hxxxx_xxxx;
    return ref_mem[int'(addr / 4)];
  endfunction

  initial begin
    logic [7:0]  img [$];
    logic [31:0] words_b [4];
    logic [31:0] addr;
    logic        en;
    int          nw;

    rst = 1'b1; rst_b = 1'b1;
    rom_en = 1'b1; rom_addr = '0; rom_en_b = 1'b0; rom_addr_b = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; load_restart = 1'b0;
    load_valid_b = 1'b0; load_data_b = '0; load_last_b = 1'b0; load_restart_b = 1'b0;

    @(posedge clk); #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_rom_inst", rom_inst, 32'h0);
    rst = 1'b0; rst_b = 1'b0;
    idle(0, 1'b0);
    chk("load_ignores_fetch", rom_inst, 32'h0);

    // Reference image of two words
    img = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};
    load_bytes(0, img, 1'b1, 1'b0);
    chk("img8_done", 32'(load_done), 32'd1);
    chk("img8_cpu_rst_edge", 32'(cpu_rst), 32'd1);
    idle(0, 1'b0);
    chk("img8_cpu_rst_rel", 32'(cpu_rst), 32'd0);
    chk("img8_ready", 32'(load_ready), 32'd0);
    rd_chk("rd_w0", 0, 1'b1, 32'h0, 32'h3C011234);
    rd_chk("rd_w1", 0, 1'b1, 32'h4, 32'h34215678);
    rd_chk("rd_misaligned", 0, 1'b1, 32'h6, 32'h0);
    rd_chk("rd_disabled", 0, 1'b0, 32'h4, 32'h0);
    rd_chk("rd_out_of_range", 0, 1'b1, 32'h1004, 32'h0);

    // Truncated image: six bytes ending mid-word
    idle(0, 1'b1);
    chk("restart_ready", 32'(load_ready), 32'd1);
    chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_bytes(0, img, 1'b1, 1'b0);
    chk("trunc_error", 32'(load_error), 32'd1);
    chk("trunc_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("trunc_done", 32'(load_done), 32'd0);
    rd_chk("trunc_no_fetch", 0, 1'b1, 32'h0, 32'h0);
    idle(0, 1'b0);
    chk("trunc_error_sticky", 32'(load_error), 32'd1);
    idle(0, 1'b1);
    chk("trunc_restart_err", 32'(load_error), 32'd0);
    chk("trunc_restart_ready", 32'(load_ready), 32'd1);
    img = '{8'h99, 8'h88, 8'h77, 8'h66};
    load_bytes(0, img, 1'b1, 1'b0);
    rd_chk("trunc_w0_new", 0, 1'b1, 32'h0, 32'h99887766);
    rd_chk("trunc_w1_kept", 0, 1'b1, 32'h4, 32'h34215678);

    // Reset in the middle of a load
    idle(0, 1'b1);
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    load_bytes(0, img, 1'b0, 1'b0);
    rst = 1'b1; #1;
    chk("midrst_ready", 32'(load_ready), 32'd1);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load_bytes(0, img, 1'b1, 1'b0);
    chk("midrst_done", 32'(load_done), 32'd1);
    rd_chk("midrst_w0", 0, 1'b1, 32'h0, 32'h01020304);
    rd_chk("midrst_w1", 0, 1'b1, 32'h4, 32'h05060708);

    // Randomized images with valid gaps and ignored restarts during LOAD
    for (int it = 0; it < 4; it++) begin
      idle(0, 1'b1);
      ref_mem.delete();
      nw = $urandom_range(2, 12);
      img = {};
      for (int i = 0; i < nw * 4; i++) img.push_back(8'($urandom));
      for (int w = 0; w < nw; w++)
        ref_mem[w] = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
      load_bytes(0, img, 1'b1, 1'b1);
      chk($sformatf("rand%0d_done", it), 32'(load_done), 32'd1);
      for (int k = 0; k < 12; k++) begin
        en = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 3))
          0, 1: addr = 32'($urandom_range(0, nw - 1)) * 4;
          2:    addr = 32'($urandom_range(0, nw - 1)) * 4 + 32'($urandom_range(1, 3));
          default: addr = 32'h1000 + (32'($urandom) & 32'h0FFF_FFFC);
        endcase
        rd_chk($sformatf("rand%0d_rd%0d", it, k), 0, en, addr, model_read(en, addr));
      end
    end

    // Small store: overflow past four words
    img = {};
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    for (int w = 0; w < 4; w++)
      words_b[w] = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
    load_bytes(1, img, 1'b0, 1'b0);
    chk("full_still_load", 32'(load_ready_b), 32'd1);
    chk("full_no_error", 32'(load_error_b), 32'd0);
    send(1, 8'hA5, 1'b0, 1'b0);
    chk("ovf_error", 32'(load_error_b), 32'd1);
    chk("ovf_ready", 32'(load_ready_b), 32'd0);
    chk("ovf_cpu_rst", 32'(cpu_rst_b), 32'd1);
    send(1, 8'h5A, 1'b0, 1'b0);
    send(1, 8'hC3, 1'b0, 1'b0);
    send(1, 8'h3C, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("ovf_restart_ready", 32'(load_ready_b), 32'd1);
    img = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    load_bytes(1, img, 1'b1, 1'b0);
    chk("small_done", 32'(load_done_b), 32'd1);
    rd_chk("small_w0", 1, 1'b1, 32'h0, 32'hCAFEF00D);
    rd_chk("small_w1", 1, 1'b1, 32'h4, words_b[1]);
    rd_chk("small_w2", 1, 1'b1, 32'h8, words_b[2]);
    rd_chk("small_w3", 1, 1'b1, 32'hC, words_b[3]);
    rd_chk("small_oob", 1, 1'b1, 32'h10, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH_LOG2, default 10: instruction store depth is 2^ROM_DEPTH_LOG2 32-bit words.
REQ-002 SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  rising-edge clock shared with the CPU core.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rom_en  input  1  fetch enable from the CPU PC stage.
REQ-006 rom_addr  input  32  byte address from the CPU PC stage.
REQ-007 rom_inst  output  32  instruction word returned to the CPU IF stage.
REQ-008 load_valid  input  1  a program byte is offered on load_data.
REQ-009 load_data  input  8  program byte.
REQ-010 load_last  input  1  qualifies the offered byte as the final byte of the image.
REQ-011 load_ready  output  1  loader accepts a byte this cycle.
REQ-012 load_restart  input  1  request to discard the image and reload.
REQ-013 cpu_rst  output  1  registered reset to the CPU core, high while no valid image.
REQ-014 load_done  output  1  image complete, CPU running.
REQ-015 load_error  output  1  sticky load failure flag.

Function
REQ-016 States SHALL be LOAD, RUN and ERROR; the reset state is LOAD.
REQ-017 A byte is accepted on a rising edge with load_valid=1 and load_ready=1; load_ready=1 only in LOAD.
REQ-018 Bytes SHALL assemble big-endian: the first byte of a word goes to bits 31:24 and the fourth to bits 7:0; a 2-bit byte counter wraps 3->0.
REQ-019 On the edge accepting the fourth byte, the word SHALL be written to mem[word_ptr] and word_ptr SHALL increment; word_ptr is ROM_DEPTH_LOG2+1 bits wide.
REQ-020 load_last with byte counter=3 SHALL complete that write and move LOAD->RUN on the same edge.
REQ-021 load_last with byte counter!=3 SHALL move LOAD->ERROR; the partial word is not written.
REQ-022 An accepted byte while word_ptr=2^ROM_DEPTH_LOG2 (store full) SHALL move LOAD->ERROR with no write.
REQ-023 cpu_rst SHALL be 1 in LOAD and ERROR and 0 from the cycle after the LOAD->RUN edge.
REQ-024 load_done SHALL be 1 exactly while in RUN.
REQ-025 load_error SHALL be 1 exactly while in ERROR.
REQ-026 load_restart=1 in RUN or ERROR SHALL move to LOAD and clear word_ptr and the byte counter; it is ignored in LOAD.
REQ-027 Read path SHALL be combinational, zero-latency: rom_inst=mem[rom_addr[ROM_DEPTH_LOG2+1:2]] when rom_en=1, the state is RUN, rom_addr[1:0]=0 and rom_addr[31:ROM_DEPTH_LOG2+2]=0.
REQ-028 rom_inst SHALL be 32'h0 in all other cases, including out-of-range and misaligned addresses.
REQ-029 Words never written since the last restart read as whatever the store holds; the store itself is not cleared.

Reset
REQ-030 While rst=1: state=LOAD, word_ptr=0, byte counter=0, cpu_rst=1, load_ready=1, load_done=0, load_error=0, rom_inst=0.
REQ-031 rst asserted mid-load SHALL abandon the partial image; a new load starts at word 0.

Structure
REQ-032 ROM_DEPTH_LOG2 default, state encodings, and the instruction and address bus widths SHALL live in the shared global definitions.
REQ-033 The storage SHALL be one sub-module, inst_rom_mem, with one synchronous write port and one asynchronous read port; the FSM, counters and assembly register stay in inst_rom_loader.

Verification
REQ-034 Load 8 bytes 3C,01,12,34,34,21,56,78 with load_last on the 8th byte -> mem[0]=3C011234, mem[1]=34215678, cpu_rst=0 one cycle later, load_done=1.
REQ-035 After REQ-034: rom_en=1, rom_addr=0x4 -> rom_inst=34215678 in the same cycle; rom_addr=0x6 or rom_en=0 -> rom_inst=0.
REQ-036 Load 6 bytes with load_last on the 6th -> load_error=1, cpu_rst stays 1, mem[1] unchanged; load_restart -> LOAD, load_error=0.
REQ-037 ROM_DEPTH_LOG2=2: load 16 bytes without load_last, then 1 more byte -> ERROR; mem[0..3] intact; the 17th byte is not written.
REQ-038 Assert rst after 5 of 8 bytes, then reload the full 8 bytes -> the first word lands at mem[0], correct values, load_done=1.
REQ-039 Hold load_valid=1 with gaps in load_valid, and assert load_restart during LOAD -> restart ignored; each byte accepted exactly once.
